// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the fetch stage: architectural widths, the
// canonical NOP encoding, the default reset PC and the fetch-queue entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;
    localparam int unsigned     QDEPTH_DEFAULT   = 2;

    // Clears the two byte-offset bits so the address names a 32-bit word.
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // One buffered fetch result as presented to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;

    // Word-align a byte address (masking keeps every input bit in the cone).
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO used for both the {pc,insn} buffer and the in-order
// PC tag queue. Synchronous clear empties it in one cycle; a push is accepted
// on full only when a pop happens in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; clear behaves like reset.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1'b1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1'b1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Entry storage; contents of empty slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_checker.sv
// Protocol invariants of the fetch stage, kept out of the datapath files.
module instruction_fetch_checker #(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned CW     = $clog2(QDEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    input logic          i_dq_push,
    input logic          i_dq_pop,
    input logic          i_dq_full,
    input logic          i_tq_push,
    input logic          i_tq_pop,
    input logic          i_tq_full,
    input logic          i_tq_empty,
    input logic [CW-1:0] i_tq_count,
    input logic [CW-1:0] i_outstanding,
    input logic [CW-1:0] i_drop_cnt
);

    // The issue rule guarantees the data queue never overflows.
    a_dq_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_dq_push && i_dq_full && !i_dq_pop));

    a_tq_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_tq_push && i_tq_full && !i_tq_pop));

    // Every kept response must find its PC tag waiting.
    a_tq_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(i_tq_pop && i_tq_empty));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
        i_outstanding <= CW'(QDEPTH));

    // In-flight requests are either tagged (live) or counted for dropping.
    a_tag_drop_balance: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, i_tq_count} + {1'b0, i_drop_cnt}) == {1'b0, i_outstanding});

endmodule

// File: rtl/instruction_fetch.sv
// RV64 instruction fetch stage: PC register, in-order word requests to
// instruction memory, a 2-entry {pc,insn} buffer toward decode, and redirect
// handling that silently drops responses still in flight.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- a redirect to a target with
// nonzero low bits raises a sticky misalign_fault and halts issue instead of
// being silently word-aligned.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = QDEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instruction,
    output logic            misalign_fault
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned DW = XLEN + ILEN;
    localparam logic [CW:0] QDEPTH_L = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_misalign;
    logic            w_accept;
    logic            w_resp_keep;
    logic            w_id_pop;
    logic [CW:0]     w_inflight;
    logic            w_has_room;

    fetch_entry_t    w_dq_head;
    fetch_entry_t    w_dq_push_data;
    logic            w_dq_full;
    logic            w_dq_empty;
    logic [CW-1:0]   w_dq_count;

    logic [XLEN-1:0] w_tq_head;
    logic            w_tq_full;
    logic            w_tq_empty;
    logic [CW-1:0]   w_tq_count;

    // Requests plus buffered results may never exceed the queue depth, so a
    // response always has a slot waiting for it (memory cannot be stalled).
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_dq_count};
    assign w_has_room     = (w_inflight < QDEPTH_L);
    assign imem_req_valid = !reset && !redirect && w_has_room && !w_misalign;
    assign imem_addr      = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response is kept only when no stale responses remain to be dropped;
    // a response coinciding with a redirect is itself stale.
    assign w_resp_keep    = imem_resp_valid && !redirect && (r_drop_cnt == {CW{1'b0}});
    assign w_dq_push_data = '{pc: w_tq_head, insn: imem_resp_data};
    assign w_id_pop       = id_valid && id_ready;

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH(DW), .CW(CW)) u_data_q (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect),
        .i_push  (w_resp_keep),
        .i_data  (w_dq_push_data),
        .i_pop   (w_id_pop),
        .o_data  (w_dq_head),
        .o_full  (w_dq_full),
        .o_empty (w_dq_empty),
        .o_count (w_dq_count)
    );

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH(XLEN), .CW(CW)) u_tag_q (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect),
        .i_push  (w_accept),
        .i_data  (r_pc),
        .i_pop   (w_resp_keep),
        .o_data  (w_tq_head),
        .o_full  (w_tq_full),
        .o_empty (w_tq_empty),
        .o_count (w_tq_count)
    );

    // Decode sees the queue head, or zeros when nothing is valid.
    always_comb begin
        id_valid       = !w_dq_empty;
        id_pc          = {XLEN{1'b0}};
        id_instruction = {ILEN{1'b0}};
        if (!w_dq_empty) begin
            id_pc          = w_dq_head.pc;
            id_instruction = w_dq_head.insn;
        end else begin
            id_pc          = {XLEN{1'b0}};
            id_instruction = {ILEN{1'b0}};
        end
    end

    // PC: reset, redirect target, or sequential advance on request accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            // Misaligned targets are kept verbatim for fault reporting;
            // aligned targets are unchanged by alignment anyway.
            r_pc <= redirect_pc;
`else
            r_pc <= word_align(redirect_pc);
`endif
        end else if (w_accept) begin
            r_pc <= r_pc + 64'd4;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Outstanding-request and stale-response counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= {CW{1'b0}};
            r_drop_cnt    <= {CW{1'b0}};
        end else if (redirect) begin
            // Everything still in flight after this cycle is stale.
            r_outstanding <= r_outstanding - CW'(imem_resp_valid);
            r_drop_cnt    <= r_outstanding - CW'(imem_resp_valid);
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);
            if (imem_resp_valid && (r_drop_cnt != {CW{1'b0}})) begin
                r_drop_cnt <= r_drop_cnt - CW'(1'b1);
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (redirect) begin
            r_misalign <= (redirect_pc[1:0] != 2'b00);
        end else begin
            r_misalign <= r_misalign;
        end
    end

    assign w_misalign = r_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign misalign_fault = w_misalign;

    instruction_fetch_checker #(.QDEPTH(QDEPTH), .CW(CW)) u_checker (
        .clk           (clk),
        .reset         (reset),
        .i_dq_push     (w_resp_keep),
        .i_dq_pop      (w_id_pop),
        .i_dq_full     (w_dq_full),
        .i_tq_push     (w_accept),
        .i_tq_pop      (w_resp_keep),
        .i_tq_full     (w_tq_full),
        .i_tq_empty    (w_tq_empty),
        .i_tq_count    (w_tq_count),
        .i_outstanding (r_outstanding),
        .i_drop_cnt    (r_drop_cnt)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural memory with random latency and
// ready, a program-order reference stream feeding a scoreboard queue, and a
// monitor that checks every instruction decode accepts.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        misalign_fault;

    instruction_fetch #(.RESET_PC(64'h0), .QDEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction),
        .misalign_fault  (misalign_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    typedef struct { logic [63:0] addr; int due; } pend_t;
    typedef struct { logic [63:0] pc; logic [31:0] insn; } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    logic [63:0] model_pc   = 64'h0;
    bit          model_hold = 1'b0;
    logic [63:0] last_acc   = 64'h0;
    int          cyc        = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          rdy_pct    = 100;
    bit          rdy_low    = 1'b0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory response side: in-order, random latency, random request ready.
    initial begin
        pend_t p;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_req_ready = !rdy_low && (int'($urandom_range(99)) < rdy_pct);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(p.addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // Memory request side: record each accepted request.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
                last_acc = imem_addr;
            end
        end
    end

    // Monitor: every decode handshake is scored against the program stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && id_valid && id_ready) begin
                n_out++;
                if (exp_q.size() == 0 && !model_hold) begin
                    exp_q.push_back('{model_pc, mem_word(model_pc)});
                    model_pc = model_pc + 64'd4;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got pc %h while none expected", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e.pc);
                    chk("id_instruction", {32'h0, id_instruction}, {32'h0, e.insn});
                end
            end else if (!reset && !id_valid) begin
                chk("idle_id_pc", id_pc, 64'h0);
            end
        end
    end

    // Redirect for one cycle, then restart the reference stream at the target.
    task automatic do_redirect(input logic [63:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        #1;
        chk("req_valid_in_redirect", {63'h0, imem_req_valid}, 64'h0);
        @(posedge clk);
        #2;
        redirect = 1'b0;
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
            model_hold = 1'b1;
        end else begin
            model_hold = 1'b0;
            model_pc   = tgt;
        end
`else
        model_hold = 1'b0;
        model_pc   = {tgt[63:2], 2'b00};
`endif
    endtask

    task automatic wait_id_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (id_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: id_valid never rose got 0 expected 1", nm);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish got timeout expected finish");
        $fatal(1);
    end

    // Directed scenarios, then a randomized run.
    initial begin
        logic [63:0] tgt;
        bit          found;
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        id_ready    = 1'b1;

        // Reset (with an ignored redirect).
        repeat (3) step();
        #1;
        chk("reset_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("reset_id_valid", {63'h0, id_valid}, 64'h0);
        chk("reset_id_pc", id_pc, 64'h0);
        chk("reset_id_instruction", {32'h0, id_instruction}, 64'h0);
        chk("reset_misalign", {63'h0, misalign_fault}, 64'h0);
        chk("reset_pc", imem_addr, 64'h0);
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("cycle0_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("cycle0_addr", imem_addr, 64'h0);
        step();
        chk("cycle1_id_valid", {63'h0, id_valid}, 64'h0);
        step();
        chk("cycle2_id_valid", {63'h0, id_valid}, 64'h1);
        chk("cycle2_id_pc", id_pc, 64'h0);
        repeat (6) step();

        // Decode stall: queue fills and issue stops.
        id_ready = 1'b0;
        repeat (5) step();
        chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("stall_id_valid", {63'h0, id_valid}, 64'h1);
        id_ready = 1'b1;
        repeat (4) step();

        // Redirect with two requests outstanding and none responding.
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pend_q.size() == 2 && !imem_resp_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("two_outstanding_reached", {63'h0, found}, 64'h1);
        do_redirect(64'h100);
        lat_min = 1;
        lat_max = 1;
        wait_id_valid("redirect_0x100");
        chk("redirect_target_pc", id_pc, 64'h100);
        repeat (3) step();

        // Redirect coinciding with a response and a decode pop.
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (imem_resp_valid && id_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("resp_pop_coincide_reached", {63'h0, found}, 64'h1);
        do_redirect(64'h2000);
        chk("queue_cleared", {63'h0, id_valid}, 64'h0);
        wait_id_valid("redirect_0x2000");
        chk("redirect2_target_pc", id_pc, 64'h2000);
        repeat (4) step();

        // Memory not ready: address holds and pc does not advance.
        rdy_low = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("held_addr", imem_addr, last_acc + 64'd4);
            step();
        end
        rdy_low = 1'b0;
        repeat (6) step();

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
        do_redirect(64'h102);
        chk("misalign_set", {63'h0, misalign_fault}, 64'h1);
        for (int k = 0; k < 6; k++) begin
            chk("misalign_no_req", {63'h0, imem_req_valid}, 64'h0);
            step();
        end
        chk("misalign_id_idle", {63'h0, id_valid}, 64'h0);
        do_redirect(64'h200);
        chk("misalign_cleared", {63'h0, misalign_fault}, 64'h0);
        wait_id_valid("resume_0x200");
        chk("resume_pc", id_pc, 64'h200);
`else
        do_redirect(64'h102);
        chk("misalign_tied_low", {63'h0, misalign_fault}, 64'h0);
        wait_id_valid("aligned_0x100");
        chk("aligned_target_pc", id_pc, 64'h100);
`endif
        repeat (4) step();

        // Randomized traffic with occasional redirects, including a wrap.
        lat_min = 1;
        lat_max = 3;
        rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            id_ready = (int'($urandom_range(99)) < 75);
            if (i == 1500 || $urandom_range(39) == 0) begin
                tgt = {$urandom, $urandom};
                if (i == 1500) begin
                    tgt = 64'hFFFF_FFFF_FFFF_FFF0;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt[1:0] = 2'b00;
`endif
                do_redirect(tgt);
            end else begin
                step();
            end
        end
        id_ready = 1'b1;
        repeat (10) step();
        n_cmp++;
        if (n_out < 500) begin
            n_bad++;
            $display("FAIL throughput: got %0d instructions expected at least 500", n_out);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
